gb_register_file: RTL and testbench

Parametrised CPU register file built from byte-wide storage cells, organised as NUM_PAIRS 16-bit pairs (default BC, DE, HL, AF). It supports byte and pair access, single-cycle pair increment/decrement (for HL+/HL−, BC/DE counters and similar), a dedicated flag-nibble write, and a hard-wired mask on the flag byte. It sits between the CPU decoder/ALU and the datapath muxes, and replaces per-register instances with one block.

---
 rtl/gb_register_file.sv | 102 ++++++++++
 tb/tb_gb_register_file.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_register_file.sv
// Byte-organised CPU register file: byte/pair reads and writes,
// single-cycle pair inc/dec and a masked flag byte.
module gb_register_file #(
    parameter int WIDTH     = 8,
    parameter int NUM_PAIRS = 4,
    parameter int FLAG_PAIR = 3,
    parameter logic [WIDTH-1:0] FLAG_MASK = WIDTH'(8'hF0),
    parameter logic [2*WIDTH*NUM_PAIRS-1:0] RESET_VALUE =
        (2*WIDTH*NUM_PAIRS)'(64'h01B0_014D_00D8_0013),
    localparam int SW = $clog2(2*NUM_PAIRS),
    localparam int PW = $clog2(NUM_PAIRS)
) (
    input  logic               i_Clk,
    input  logic               i_nRst,
    input  logic               i_Enable,
    input  logic [SW-1:0]      i_RdSelA,
    input  logic [SW-1:0]      i_RdSelB,
    output logic [WIDTH-1:0]   o_RdA,
    output logic [WIDTH-1:0]   o_RdB,
    input  logic [PW-1:0]      i_RdSelPair,
    output logic [2*WIDTH-1:0] o_RdPair,
    output logic [WIDTH-1:0]   o_Flags,
    input  logic               i_Wr8,
    input  logic [SW-1:0]      i_WrSel8,
    input  logic [WIDTH-1:0]   i_WrData8,
    input  logic               i_WrPair,
    input  logic [PW-1:0]      i_WrSelPair,
    input  logic [2*WIDTH-1:0] i_WrDataPair,
    input  logic [1:0]         i_IncDec,
    input  logic [PW-1:0]      i_IncDecSel,
    input  logic               i_WrFlags,
    input  logic [WIDTH-1:0]   i_FlagData
);

    localparam int NB = 2*NUM_PAIRS;
    localparam int FB = 2*FLAG_PAIR + 1;

    logic [WIDTH-1:0]   regs_q [NB];
    logic [WIDTH-1:0]   regs_d [NB];
    logic [WIDTH-1:0]   rd_a, rd_b;
    logic [2*WIDTH-1:0] rd_pair;
    logic [2*WIDTH-1:0] id_cur, id_nxt;
    logic               id_act;

    function automatic logic [WIDTH-1:0] rst_byte(input int b);
        logic [WIDTH-1:0] v;
        v = RESET_VALUE[(b/2)*2*WIDTH + ((b%2 == 0) ? WIDTH : 0) +: WIDTH];
        if (b == FB) v = v & FLAG_MASK;
        return v;
    endfunction

    // Select loops make out-of-range selects read as zero.
    always_comb begin
        rd_a    = '0;
        rd_b    = '0;
        rd_pair = '0;
        id_cur  = '0;
        for (int b = 0; b < NB; b++) begin
            if (i_RdSelA == SW'(b)) rd_a = regs_q[b];
            if (i_RdSelB == SW'(b)) rd_b = regs_q[b];
        end
        for (int p = 0; p < NUM_PAIRS; p++) begin
            if (i_RdSelPair == PW'(p))
                rd_pair = {regs_q[2*p], regs_q[2*p+1]};
            if (i_IncDecSel == PW'(p))
                id_cur = {regs_q[2*p], regs_q[2*p+1]};
        end
    end

    assign id_act = i_IncDec[0] ^ i_IncDec[1];
    assign id_nxt = i_IncDec[0] ? id_cur + (2*WIDTH)'(1)
                                : id_cur - (2*WIDTH)'(1);

    // Lowest priority source first; later assignments win per byte.
    always_comb begin
        for (int b = 0; b < NB; b++) regs_d[b] = regs_q[b];
        if (i_WrFlags) regs_d[FB] = i_FlagData;
        for (int p = 0; p < NUM_PAIRS; p++)
            if (id_act && i_IncDecSel == PW'(p))
                {regs_d[2*p], regs_d[2*p+1]} = id_nxt;
        for (int b = 0; b < NB; b++)
            if (i_Wr8 && i_WrSel8 == SW'(b)) regs_d[b] = i_WrData8;
        for (int p = 0; p < NUM_PAIRS; p++)
            if (i_WrPair && i_WrSelPair == PW'(p))
                {regs_d[2*p], regs_d[2*p+1]} = i_WrDataPair;
        regs_d[FB] = regs_d[FB] & FLAG_MASK;
    end

    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            for (int b = 0; b < NB; b++) regs_q[b] <= rst_byte(b);
        end else if (i_Enable) begin
            for (int b = 0; b < NB; b++) regs_q[b] <= regs_d[b];
        end
    end

    assign o_RdA    = rd_a;
    assign o_RdB    = rd_b;
    assign o_RdPair = rd_pair;
    assign o_Flags  = regs_q[FB];

endmodule

// File: tb/tb_gb_register_file.sv
// Directed bench for gb_register_file: reset, flag mask, wrap,
// precedence, enable gating and async reset.
module tb_gb_register_file;

    logic        i_Clk = 1'b0;
    logic        i_nRst;
    logic        i_Enable;
    logic [2:0]  i_RdSelA, i_RdSelB;
    logic [7:0]  o_RdA, o_RdB;
    logic [1:0]  i_RdSelPair;
    logic [15:0] o_RdPair;
    logic [7:0]  o_Flags;
    logic        i_Wr8;
    logic [2:0]  i_WrSel8;
    logic [7:0]  i_WrData8;
    logic        i_WrPair;
    logic [1:0]  i_WrSelPair;
    logic [15:0] i_WrDataPair;
    logic [1:0]  i_IncDec;
    logic [1:0]  i_IncDecSel;
    logic        i_WrFlags;
    logic [7:0]  i_FlagData;

    int n_chk  = 0;
    int n_fail = 0;

    gb_register_file dut (
        .i_Clk        (i_Clk),
        .i_nRst       (i_nRst),
        .i_Enable     (i_Enable),
        .i_RdSelA     (i_RdSelA),
        .i_RdSelB     (i_RdSelB),
        .o_RdA        (o_RdA),
        .o_RdB        (o_RdB),
        .i_RdSelPair  (i_RdSelPair),
        .o_RdPair     (o_RdPair),
        .o_Flags      (o_Flags),
        .i_Wr8        (i_Wr8),
        .i_WrSel8     (i_WrSel8),
        .i_WrData8    (i_WrData8),
        .i_WrPair     (i_WrPair),
        .i_WrSelPair  (i_WrSelPair),
        .i_WrDataPair (i_WrDataPair),
        .i_IncDec     (i_IncDec),
        .i_IncDecSel  (i_IncDecSel),
        .i_WrFlags    (i_WrFlags),
        .i_FlagData   (i_FlagData)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_Wr8    = 1'b0;
        i_WrPair = 1'b0;
        i_IncDec = 2'b00;
        i_WrFlags = 1'b0;
    endtask

    task automatic tick();
        @(posedge i_Clk);
        @(negedge i_Clk);
    endtask

    task automatic chk_pair(input string tag, input logic [1:0] p,
                            input logic [15:0] exp);
        i_RdSelPair = p;
        #1;
        check(tag, o_RdPair, exp);
    endtask

    task automatic wr_pair(input logic [1:0] p, input logic [15:0] d);
        idle();
        i_WrPair = 1'b1;
        i_WrSelPair = p;
        i_WrDataPair = d;
        tick();
        idle();
    endtask

    logic [15:0] rst_tab [4];

    initial begin
        rst_tab[0] = 16'h0013;
        rst_tab[1] = 16'h00D8;
        rst_tab[2] = 16'h014D;
        rst_tab[3] = 16'h01B0;

        i_nRst = 1'b1;
        i_Enable = 1'b1;
        i_RdSelA = '0;
        i_RdSelB = '0;
        i_RdSelPair = '0;
        i_WrSel8 = '0;
        i_WrData8 = '0;
        i_WrSelPair = '0;
        i_WrDataPair = '0;
        i_IncDecSel = '0;
        i_FlagData = '0;
        idle();

        // Mid-cycle asynchronous reset
        #13 i_nRst = 1'b0;
        #1;
        for (int p = 0; p < 4; p++)
            chk_pair($sformatf("rst_pair%0d", p), 2'(p), rst_tab[p]);
        check("rst_flags", {8'h0, o_Flags}, 16'h00B0);
        @(negedge i_Clk);
        i_nRst = 1'b1;

        // Flag mask on byte write
        i_Wr8 = 1'b1;
        i_WrSel8 = 3'd7;
        i_WrData8 = 8'hFF;
        tick();
        idle();
        i_RdSelA = 3'd7;
        i_RdSelB = 3'd6;
        #1;
        check("fmask_byte", {8'h0, o_RdA}, 16'h00F0);
        check("fmask_flags", {8'h0, o_Flags}, 16'h00F0);
        check("fmask_a", {8'h0, o_RdB}, 16'h0001);

        // Flag mask on pair write
        wr_pair(2'd3, 16'h123F);
        chk_pair("fmask_pair", 2'd3, 16'h1230);

        // Wrap-around
        wr_pair(2'd2, 16'hFFFF);
        i_IncDec = 2'b01;
        i_IncDecSel = 2'd2;
        tick();
        idle();
        chk_pair("inc_wrap", 2'd2, 16'h0000);
        i_IncDec = 2'b10;
        tick();
        idle();
        chk_pair("dec_wrap", 2'd2, 16'hFFFF);

        wr_pair(2'd1, 16'h00FF);
        i_IncDec = 2'b01;
        i_IncDecSel = 2'd1;
        tick();
        idle();
        chk_pair("inc_carry", 2'd1, 16'h0100);

        // Back-to-back increments
        wr_pair(2'd1, 16'h00FE);
        i_IncDec = 2'b01;
        i_IncDecSel = 2'd1;
        tick();
        chk_pair("inc_b2b_1", 2'd1, 16'h00FF);
        tick();
        idle();
        chk_pair("inc_b2b_2", 2'd1, 16'h0100);

        // Pair write beats byte write and inc
        i_WrPair = 1'b1;
        i_WrSelPair = 2'd2;
        i_WrDataPair = 16'h1234;
        i_Wr8 = 1'b1;
        i_WrSel8 = 3'd4;
        i_WrData8 = 8'hAA;
        i_IncDec = 2'b01;
        i_IncDecSel = 2'd2;
        tick();
        idle();
        chk_pair("prec_pair", 2'd2, 16'h1234);

        // Byte write overrides only its half of the inc result
        wr_pair(2'd2, 16'h10FF);
        i_Wr8 = 1'b1;
        i_WrSel8 = 3'd5;
        i_WrData8 = 8'h55;
        i_IncDec = 2'b01;
        i_IncDecSel = 2'd2;
        tick();
        idle();
        chk_pair("prec_byte", 2'd2, 16'h1155);

        // Enable low blocks every strobe
        i_Enable = 1'b0;
        i_Wr8 = 1'b1;
        i_WrSel8 = 3'd0;
        i_WrData8 = 8'h99;
        i_WrPair = 1'b1;
        i_WrSelPair = 2'd1;
        i_WrDataPair = 16'hAAAA;
        i_IncDec = 2'b01;
        i_IncDecSel = 2'd2;
        i_WrFlags = 1'b1;
        i_FlagData = 8'hFF;
        tick();
        idle();
        i_Enable = 1'b1;
        chk_pair("en_bc", 2'd0, 16'h0013);
        chk_pair("en_de", 2'd1, 16'h0100);
        chk_pair("en_hl", 2'd2, 16'h1155);
        chk_pair("en_af", 2'd3, 16'h1230);
        check("en_flags", {8'h0, o_Flags}, 16'h0030);

        // Flag write alongside independent byte write and inc
        i_WrFlags = 1'b1;
        i_FlagData = 8'h5A;
        i_Wr8 = 1'b1;
        i_WrSel8 = 3'd0;
        i_WrData8 = 8'h77;
        i_IncDec = 2'b01;
        i_IncDecSel = 2'd1;
        tick();
        idle();
        i_RdSelA = 3'd6;
        #1;
        check("wf_flags", {8'h0, o_Flags}, 16'h0050);
        check("wf_a", {8'h0, o_RdA}, 16'h0012);
        chk_pair("wf_bc", 2'd0, 16'h7713);
        chk_pair("wf_de", 2'd1, 16'h0101);

        // Async reset discards a pending write
        i_WrPair = 1'b1;
        i_WrSelPair = 2'd0;
        i_WrDataPair = 16'hBEEF;
        #2 i_nRst = 1'b0;
        chk_pair("arst_now", 2'd0, 16'h0013);
        @(posedge i_Clk);
        #1;
        check("arst_edge", o_RdPair, 16'h0013);
        @(negedge i_Clk);
        idle();
        i_nRst = 1'b1;
        tick();
        chk_pair("arst_bc", 2'd0, 16'h0013);
        chk_pair("arst_hl", 2'd2, 16'h014D);
        check("arst_flags", {8'h0, o_Flags}, 16'h00B0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
